// File: rtl/aes_pkg.sv
// Shared encodings for the AES round sequencer: key lengths, round counts,
// round kinds and controller states.
package aes_pkg;

    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] MODE_DEC  = 2'd1;
    localparam logic [1:0] MODE_SELF = 2'd2;

    typedef enum logic [1:0] {
        RK_INIT  = 2'd0,
        RK_MID   = 2'd1,
        RK_FINAL = 2'd2
    } rnd_kind_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_LOAD,
        S_ROUND,
        S_FINISH
    } state_t;

    // Codes 0 and 3 both select AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_addr_gen.sv
// Round classification and first round-key word address for round r.
// The inverse cipher walks the key schedule from the end backwards.
module aes_round_addr_gen
    import aes_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [3:0]        r,
    input  logic [3:0]        nr,
    input  logic              inv,
    output rnd_kind_t         kind,
    output logic [ADDR_W-1:0] word_addr
);

    logic [3:0] rsel;

    always_comb begin
        rsel      = inv ? (nr - r) : r;
        word_addr = ADDR_W'({rsel, 2'b00});
        kind      = RK_MID;
        if (r == 4'd0)
            kind = RK_INIT;
        else if (r == nr)
            kind = RK_FINAL;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Controller for the shared iterative AES round datapath: key-schedule
// caching, state load, round command issue and encrypt/decrypt self-test.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int TXT_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [1:0]        mode,
    input  logic              key_new,
    output logic              kx_start,
    output logic [1:0]        kx_len,
    input  logic              kx_done,
    output logic              st_load,
    output logic              st_src,
    output logic              rnd_valid,
    input  logic              dp_ready,
    output logic [3:0]        rnd_idx,
    output logic [1:0]        rnd_kind,
    output logic              rnd_inv,
    output logic [ADDR_W-1:0] word_addr,
    input  logic [TXT_W-1:0]  pt_in,
    input  logic [TXT_W-1:0]  dp_state,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    state_t            state;
    logic [3:0]        nr;
    logic [3:0]        r;
    logic [1:0]        mode_q;
    logic              kcache_vld;
    logic [1:0]        cached_len;
    logic              pass2;
    rnd_kind_t         kind;
    logic [ADDR_W-1:0] addr;

    aes_round_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .r         (r),
        .nr        (nr),
        .inv       (rnd_inv),
        .kind      (kind),
        .word_addr (addr)
    );

    assign rnd_idx   = r;
    assign rnd_kind  = rnd_valid ? kind : RK_INIT;
    assign word_addr = rnd_valid ? addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            nr         <= '0;
            r          <= '0;
            mode_q     <= '0;
            kcache_vld <= 1'b0;
            cached_len <= '0;
            pass2      <= 1'b0;
            kx_start   <= 1'b0;
            kx_len     <= '0;
            st_load    <= 1'b0;
            st_src     <= 1'b0;
            rnd_valid  <= 1'b0;
            rnd_inv    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            kx_start <= 1'b0;
            st_load  <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        kx_len  <= key_len;
                        mode_q  <= mode;
                        nr      <= nr_of(key_len);
                        pass    <= 1'b0;
                        pass2   <= 1'b0;
                        st_src  <= 1'b0;
                        rnd_inv <= (mode == MODE_DEC);
                        busy    <= 1'b1;
                        // Reuse the cached schedule only for an unchanged key.
                        if (key_new || !kcache_vld || key_len != cached_len) begin
                            state    <= S_KEXP;
                            kx_start <= 1'b1;
                        end else begin
                            state   <= S_LOAD;
                            st_load <= 1'b1;
                        end
                    end
                end
                S_KEXP: begin
                    if (kx_done) begin
                        kcache_vld <= 1'b1;
                        cached_len <= kx_len;
                        state      <= S_LOAD;
                        st_load    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r         <= '0;
                    rnd_valid <= 1'b1;
                    state     <= S_ROUND;
                end
                S_ROUND: begin
                    if (dp_ready) begin
                        if (r != nr) begin
                            r <= r + 4'd1;
                        end else if (mode_q == MODE_SELF && !pass2) begin
                            pass2     <= 1'b1;
                            st_src    <= 1'b1;
                            rnd_inv   <= 1'b1;
                            rnd_valid <= 1'b0;
                            st_load   <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            rnd_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    if (mode_q == MODE_SELF)
                        pass <= (dp_state == pt_in);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: command sequences, latency,
// key caching, self-test verdict, stalls, reset and busy-start handling.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [1:0]   mode;
    logic         key_new;
    logic         kx_start;
    logic [1:0]   kx_len;
    logic         kx_done;
    logic         st_load;
    logic         st_src;
    logic         rnd_valid;
    logic         dp_ready;
    logic [3:0]   rnd_idx;
    logic [1:0]   rnd_kind;
    logic         rnd_inv;
    logic [5:0]   word_addr;
    logic [127:0] pt_in;
    logic [127:0] dp_state;
    logic         busy;
    logic         done;
    logic         pass;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.ADDR_W(6), .TXT_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .mode      (mode),
        .key_new   (key_new),
        .kx_start  (kx_start),
        .kx_len    (kx_len),
        .kx_done   (kx_done),
        .st_load   (st_load),
        .st_src    (st_src),
        .rnd_valid (rnd_valid),
        .dp_ready  (dp_ready),
        .rnd_idx   (rnd_idx),
        .rnd_kind  (rnd_kind),
        .rnd_inv   (rnd_inv),
        .word_addr (word_addr),
        .pt_in     (pt_in),
        .dp_state  (dp_state),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_valid"}, rnd_valid, 0);
        check_eq({tag, "_load"}, st_load, 0);
        check_eq({tag, "_kx"}, kx_start, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_cmd"}, {rnd_idx, rnd_kind, rnd_inv, word_addr}, 0);
    endtask

    // One complete request; every command accepted is checked against
    // the round index, kind, direction and schedule address expected.
    task automatic run_op(input logic [1:0] kl, input logic [1:0] md,
                          input logic kn, input bit rnd_rdy,
                          input int exp_kx, input int exp_done,
                          input logic exp_pass, input logic [127:0] fin_st,
                          input bit poke);
        int nr, npass, cmds, loads, kxs, dones, done_cyc, kx_due;
        int p, rr, e_kind, e_addr;
        logic e_inv, prev_stall, fin;
        logic [12:0] p_cmd;
        nr    = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
        npass = (md == 2'd2) ? 2 : 1;
        cmds = 0; loads = 0; kxs = 0; dones = 0;
        done_cyc = -1; kx_due = -1;
        prev_stall = 0; fin = 0; p_cmd = '0;
        @(negedge clk);
        start = 1; key_len = kl; mode = md; key_new = kn;
        dp_ready = 1; kx_done = 0; dp_state = fin_st;
        for (int cyc = 1; cyc <= 120 && !fin; cyc++) begin
            @(negedge clk);
            start   = poke && (cyc == 5);
            key_len = 2'($urandom_range(0, 3));
            mode    = 2'($urandom_range(0, 3));
            key_new = 1'($urandom_range(0, 1));
            if (kx_start) begin
                kxs++;
                kx_due = cyc + 3;
                check_eq("kx_len", kx_len, kl);
            end
            kx_done = (cyc == kx_due);
            if (st_load) begin
                loads++;
                check_eq("st_src", st_src, (loads == 2));
            end
            if (prev_stall) begin
                check_eq("stall_valid", rnd_valid, 1);
                check_eq("stall_cmd", {rnd_idx, rnd_kind, rnd_inv, word_addr}, p_cmd);
            end
            dp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd_valid && dp_ready) begin
                p      = cmds / (nr + 1);
                rr     = cmds % (nr + 1);
                e_inv  = (md == 2'd1) || (p == 1);
                e_kind = (rr == 0) ? 0 : (rr == nr) ? 2 : 1;
                e_addr = e_inv ? 4 * (nr - rr) : 4 * rr;
                check_eq("rnd_idx", rnd_idx, rr);
                check_eq("rnd_kind", rnd_kind, e_kind);
                check_eq("rnd_inv", rnd_inv, e_inv);
                check_eq("word_addr", word_addr, e_addr);
                cmds++;
            end
            prev_stall = rnd_valid && !dp_ready;
            p_cmd = {rnd_idx, rnd_kind, rnd_inv, word_addr};
            if (done) begin
                dones++;
                done_cyc = cyc;
                fin = 1;
            end
        end
        start = 0; dp_ready = 1; kx_done = 0;
        check_eq("done_seen", dones, 1);
        check_eq("cmd_count", cmds, npass * (nr + 1));
        check_eq("load_count", loads, npass);
        check_eq("kx_count", kxs, exp_kx);
        if (exp_done > 0)
            check_eq("done_cycle", done_cyc, exp_done);
        @(negedge clk);
        check_eq("pass", pass, exp_pass);
        check_eq("idle_busy", busy, 0);
        check_eq("done_once", done, 0);
        @(negedge clk);
        check_eq("no_queue", busy, 0);
    endtask

    logic [127:0] pt;
    bit           hit;

    initial begin
        pt = 128'h00112233_44556677_8899aabb_ccddeeff;
        pt_in = pt; dp_state = '0;
        rst = 1; start = 0; key_len = 0; mode = 0; key_new = 0;
        kx_done = 0; dp_ready = 1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 0;

        // AES-128 fresh key, then cached (13-cycle latency)
        run_op(2'd0, 2'd0, 1'b1, 0, 1, 17, 1'b0, pt, 0);
        run_op(2'd0, 2'd0, 1'b0, 0, 0, 13, 1'b0, pt, 0);
        // AES-256: expand, then decrypt on cached schedule
        run_op(2'd2, 2'd0, 1'b1, 0, 1, 21, 1'b0, pt, 0);
        run_op(2'd2, 2'd1, 1'b0, 0, 0, 17, 1'b0, pt, 0);
        // AES-192 self-test, good and corrupted final state
        run_op(2'd1, 2'd0, 1'b1, 0, 1, 19, 1'b0, pt, 0);
        run_op(2'd1, 2'd2, 1'b0, 0, 0, 29, 1'b1, pt, 0);
        run_op(2'd1, 2'd2, 1'b0, 0, 0, 29, 1'b0, pt ^ 128'h1, 0);
        // Random back-pressure
        run_op(2'd1, 2'd2, 1'b0, 1, 0, -1, 1'b1, pt, 0);
        run_op(2'd2, 2'd1, 1'b1, 1, 1, -1, 1'b0, pt, 0);
        // Key-length code 3 is AES-128; start pulsed while busy is dropped
        run_op(2'd3, 2'd3, 1'b1, 0, 1, 17, 1'b0, pt, 1);

        // Reset in the middle of round 5
        @(negedge clk);
        start = 1; key_len = 2'd3; mode = 2'd0; key_new = 0;
        hit = 0;
        for (int c = 1; c < 60 && !hit; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (rnd_valid && rnd_idx == 4'd5) hit = 1;
        end
        start = 0;
        check_eq("rnd5_reached", hit, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_idle_zero("midrst");
        repeat (3) @(negedge clk);
        check_eq("midrst_nodone", done | busy, 0);
        // Cache was invalidated, so key_new=0 still expands
        run_op(2'd3, 2'd0, 1'b0, 0, 1, 17, 1'b0, pt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
